// File: rtl/render_queue_pkg.sv
// Shared constants for the render queue: entry layout, magic values
// and the Avalon register map.
package render_queue_pkg;

  localparam int RENDER_ENTRY_W = 48;

  localparam logic [7:0] VGA_DO_RENDER      = 8'hFF;
  localparam logic [7:0] SPRITE_MAGIC_RECT  = 8'h10;
  localparam logic [7:0] SPRITE_MAGIC_LINE  = 8'h20;
  localparam logic [7:0] SPRITE_MAGIC_TEXT  = 8'h21;

  localparam int MAGIC_LO = 40;
  localparam int X_LO     = 24;
  localparam int Y_LO     = 8;
  localparam int FLAGS_LO = 0;

  localparam logic [1:0] REG_STAGE_LO = 2'd0;
  localparam logic [1:0] REG_PUSH     = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_FLUSH    = 2'd3;

  localparam logic [RENDER_ENTRY_W-1:0] RENDER_IDLE =
    {VGA_DO_RENDER, 40'h0};

  typedef struct packed {
    logic [7:0]  magic;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } render_entry_t;

  function automatic logic is_end_of_frame(
    input logic [RENDER_ENTRY_W-1:0] e
  );
    return e[MAGIC_LO +: 8] == VGA_DO_RENDER;
  endfunction

endpackage

// File: rtl/render_queue_fifo.sv
// Register-array FIFO with show-ahead read at rd_ptr.
// Ports: push/pop/flush requests, din, dout (head), count, empty, full.
module render_queue_fifo
  import render_queue_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = RENDER_ENTRY_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk50) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/render_queue.sv
// Avalon-MM render instruction queue feeding the VGA display stage.
// Ports: Avalon slave (chipselect/write/read/address/writedata/readdata),
// show-ahead consumer side (render_queue_pop_front, render_queue_dout).
module render_queue
  import render_queue_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ENTRY_W = RENDER_ENTRY_W
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               write,
  input  logic               read,
  input  logic [1:0]         address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic               render_queue_pop_front,
  output logic [ENTRY_W-1:0] render_queue_dout
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]        staging;
  logic               overflow;
  logic [7:0]         frame_cnt;
  logic               push;
  logic               flush;
  logic               stat_rd;
  logic               pop_ok;
  logic               ovf_set;
  logic [ENTRY_W-1:0] din;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      count;
  logic [8:0]         count9;
  logic               empty;
  logic               full;

  assign push    = chipselect && write && (address == REG_PUSH);
  assign flush   = chipselect && write && (address == REG_FLUSH);
  assign stat_rd = chipselect && read && (address == REG_STATUS);
  assign din     = {writedata[15:0], staging};
  assign count9  = 9'(count);

  assign pop_ok  = render_queue_pop_front && !empty && !flush;
  assign ovf_set = push && full && !pop_ok;

  // Idle entry keeps the consumer waiting for end of field.
  assign render_queue_dout = empty ? RENDER_IDLE : head;

  render_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk50 (clk50),
    .reset (reset),
    .push  (push),
    .pop   (render_queue_pop_front),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      staging   <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      readdata  <= '0;
    end else begin
      if (chipselect && write && (address == REG_STAGE_LO))
        staging <= writedata;

      if (ovf_set)
        overflow <= 1'b1;
      else if (stat_rd)
        overflow <= 1'b0;

      if (pop_ok && is_end_of_frame(head))
        frame_cnt <= frame_cnt + 8'd1;

      if (chipselect && read)
        readdata <= stat_rd ?
          {8'h0, frame_cnt, 4'h0, overflow, full, empty, count9} :
          32'h0;
    end
  end

endmodule

// File: tb/tb_render_queue.sv
// Scoreboard bench for render_queue: stimulus queues expected status
// words and popped heads; a monitor compares them when the DUT shows them.
module tb_render_queue;

  localparam logic [47:0] IDLE = 48'hFF00_0000_0000;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        render_queue_pop_front = 1'b0;
  logic [47:0] render_queue_dout;

  int checks = 0;
  int errors = 0;
  logic rd_seen = 1'b0;

  logic [31:0] rd_q  [$];
  logic [47:0] pop_q [$];

  render_queue dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (chipselect),
    .write                  (write),
    .read                   (read),
    .address                (address),
    .writedata              (writedata),
    .readdata               (readdata),
    .render_queue_pop_front (render_queue_pop_front),
    .render_queue_dout      (render_queue_dout)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) rd_seen <= chipselect && read;

  always @(negedge clk50) begin
    if (rd_seen) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL readdata_unexpected: got %h", readdata);
      end else begin
        logic [31:0] e;
        e = rd_q.pop_front();
        if (readdata !== e) begin
          errors++;
          $display("FAIL status: got %h expected %h", readdata, e);
        end
      end
    end
    if (render_queue_pop_front) begin
      checks++;
      if (pop_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %h", render_queue_dout);
      end else begin
        logic [47:0] e;
        e = pop_q.pop_front();
        if (render_queue_dout !== e) begin
          errors++;
          $display("FAIL dout: got %h expected %h",
                   render_queue_dout, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic push_ent(input logic [47:0] e);
    bus_wr(2'd0, e[31:0]);
    bus_wr(2'd1, {16'h0, e[47:32]});
  endtask

  task automatic pop_one(input logic [47:0] e);
    pop_q.push_back(e);
    render_queue_pop_front = 1'b1;
    tick();
    render_queue_pop_front = 1'b0;
  endtask

  function automatic logic [47:0] ent(input int i);
    return {8'h10, 8'(i), 32'hC0DE_0000 | 32'(i)};
  endfunction

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Idle state
    pop_one(IDLE);
    bus_rd(2'd2, 32'h0000_0200);
    bus_rd(2'd0, 32'h0000_0000);

    // Single push / pop, then staging reuse
    bus_wr(2'd0, 32'h0040_0201);
    bus_wr(2'd1, 32'h0000_0100);
    pop_one(48'h0100_0040_0201);
    bus_rd(2'd2, 32'h0000_0200);
    pop_one(IDLE);
    bus_wr(2'd1, 32'h0000_0102);
    bus_rd(2'd2, 32'h0000_0001);
    pop_one(48'h0102_0040_0201);

    // Fill, overflow, sticky flag cleared by read
    for (int i = 0; i < 64; i++) push_ent(ent(i));
    bus_rd(2'd2, 32'h0000_0440);
    push_ent(ent(99));
    bus_rd(2'd2, 32'h0000_0C40);
    bus_rd(2'd2, 32'h0000_0440);

    // Full: push and pop together
    bus_wr(2'd0, ent(64)[31:0]);
    pop_q.push_back(ent(0));
    chipselect = 1'b1; write = 1'b1; address = 2'd1;
    writedata = {16'h0, ent(64)[47:32]};
    render_queue_pop_front = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0; render_queue_pop_front = 1'b0;
    bus_rd(2'd2, 32'h0000_0440);
    for (int i = 1; i < 64; i++) pop_one(ent(i));
    pop_one(ent(64));
    bus_rd(2'd2, 32'h0000_0200);

    // End-of-frame counting and pops while empty
    push_ent(48'h20_0001_0002_03);
    push_ent(48'hFF_0004_0005_06);
    push_ent(48'h21_0007_0008_09);
    pop_one(48'h20_0001_0002_03);
    pop_one(48'hFF_0004_0005_06);
    pop_one(48'h21_0007_0008_09);
    pop_one(IDLE);
    pop_one(IDLE);
    bus_rd(2'd2, 32'h0001_0200);

    // Push with a pop while empty
    bus_wr(2'd0, 32'h1234_5678);
    pop_q.push_back(IDLE);
    chipselect = 1'b1; write = 1'b1; address = 2'd1;
    writedata = 32'h0000_109A;
    render_queue_pop_front = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0; render_queue_pop_front = 1'b0;
    bus_rd(2'd2, 32'h0001_0001);
    pop_one(48'h109A_1234_5678);

    // Flush wins over pop
    for (int i = 200; i < 205; i++) push_ent(ent(i));
    pop_q.push_back(ent(200));
    chipselect = 1'b1; write = 1'b1; address = 2'd3;
    render_queue_pop_front = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0; render_queue_pop_front = 1'b0;
    bus_rd(2'd2, 32'h0001_0200);
    push_ent(ent(210));
    push_ent(ent(211));
    push_ent(ent(212));
    pop_one(ent(210));
    pop_one(ent(211));

    // Asynchronous reset mid-drain; pop during reset ignored
    reset = 1'b1;
    #1;
    checks++;
    if (render_queue_dout !== IDLE) begin
      errors++;
      $display("FAIL async_reset_dout: got %h expected %h",
               render_queue_dout, IDLE);
    end
    pop_one(IDLE);
    reset = 1'b0;
    tick();
    bus_rd(2'd2, 32'h0000_0200);
    pop_one(IDLE);

    repeat (3) tick();
    checks++;
    if (rd_q.size() != 0 || pop_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
               rd_q.size(), pop_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
